// File: rtl/mseq_pkg.sv
// mseq_pkg: shared types and the LFSR feedback convention used by both the
// M-sequence generator bank and the receive-side checker.
//   mseq_state_e : checker synchronisation state (LOAD, VERIFY, LOCKED)
//   mseq_fb      : feedback/emitted bit = ^(state & taps)
package mseq_pkg;

  // Widest LFSR supported by the shared feedback helper.
  localparam int unsigned MSEQ_MAX_W = 64;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } mseq_state_e;

  // Callers zero-extend narrower state/tap vectors to MSEQ_MAX_W.
  function automatic logic mseq_fb(input logic [MSEQ_MAX_W-1:0] state,
                                   input logic [MSEQ_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/mseq_sat_counter.sv
// mseq_sat_counter: saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one event this cycle
//   clr      : zero the counter; wins over a simultaneous inc
//   count    : registered count, holds at all-ones
module mseq_sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mseq_checker.sv
// mseq_checker: self-synchronising M-sequence receiver. Loads W received bits
// into a local LFSR, verifies LOCK_MATCHES consecutive predictions, then
// free-runs on its own predictions and counts bit errors.
//   MSEQ_clk, MSEQ_rst         : clock, asynchronous active-high reset
//   MSEQ_seed                  : feedback tap mask (quasi-static)
//   MSEQ_in_valid, MSEQ_in_bit : received bit and its qualifier
//   MSEQ_clr_cnt               : synchronous clear of both counters
//   MSEQ_locked                : checker is in LOCKED
//   MSEQ_err_pulse             : one-cycle pulse per errored locked bit
//   MSEQ_err_cnt, MSEQ_bit_cnt : saturating error / checked-bit counters
module mseq_checker
  import mseq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned LOCK_MATCHES = 32,
  parameter int unsigned LOSS_WINDOW  = 64,
  parameter int unsigned LOSS_ERRORS  = 8,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  MSEQ_clk,
  input  logic                  MSEQ_rst,
  input  logic [DATA_WIDTH-1:0] MSEQ_seed,
  input  logic                  MSEQ_in_valid,
  input  logic                  MSEQ_in_bit,
  input  logic                  MSEQ_clr_cnt,
  output logic                  MSEQ_locked,
  output logic                  MSEQ_err_pulse,
  output logic [CNT_WIDTH-1:0]  MSEQ_err_cnt,
  output logic [CNT_WIDTH-1:0]  MSEQ_bit_cnt
);

  localparam int unsigned FILL_W  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned WPOS_W  = $clog2(LOSS_WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_ERRORS + 1);

  mseq_state_e           state, state_next;
  logic [DATA_WIDTH-1:0] sr, sr_next;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [FILL_W-1:0]     fill_cnt, fill_next;
  logic [MATCH_W-1:0]    match_cnt, match_next;
  logic [WPOS_W-1:0]     win_pos, wpos_next;
  logic [WERR_W-1:0]     win_err, werr_next;
  logic                  pulse_next;
  logic                  bit_inc, err_inc;

  // Prediction and per-bit decode terms.
  logic seed_chg, pred, bit_err, bit_match;
  logic fill_last, match_last, win_last, loss_hit;

  assign seed_chg   = (MSEQ_seed != seed_q);
  assign pred       = mseq_fb(MSEQ_MAX_W'(sr), MSEQ_MAX_W'(seed_q));
  assign bit_err    = (MSEQ_in_bit != pred);
  // An all-zero register predicts zeros forever; refuse it as a match.
  assign bit_match  = !bit_err && (sr != '0);
  assign fill_last  = (fill_cnt == FILL_W'(DATA_WIDTH - 1));
  assign match_last = (match_cnt == MATCH_W'(LOCK_MATCHES - 1));
  assign win_last   = (win_pos == WPOS_W'(LOSS_WINDOW - 1));
  assign loss_hit   = bit_err && (win_err == WERR_W'(LOSS_ERRORS - 1));

  // State register.
  always_ff @(posedge MSEQ_clk or posedge MSEQ_rst) begin
    if (MSEQ_rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a seed change restarts synchronisation.
  always_comb begin
    state_next = state;
    if (seed_chg) begin
      state_next = LOAD;
    end else if (MSEQ_in_valid) begin
      case (state)
        LOAD:    if (fill_last) state_next = VERIFY;
        VERIFY: begin
          if (!bit_match) begin
            state_next = LOAD;
          end else if (match_last) begin
            state_next = LOCKED;
          end
        end
        LOCKED:  if (loss_hit) state_next = LOAD;
        default: state_next = LOAD;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    sr_next    = sr;
    fill_next  = fill_cnt;
    match_next = match_cnt;
    wpos_next  = win_pos;
    werr_next  = win_err;
    pulse_next = 1'b0;
    bit_inc    = 1'b0;
    err_inc    = 1'b0;
    if (seed_chg) begin
      fill_next  = '0;
      match_next = '0;
      wpos_next  = '0;
      werr_next  = '0;
    end else if (MSEQ_in_valid) begin
      case (state)
        LOAD: begin
          sr_next    = {sr[DATA_WIDTH-2:0], MSEQ_in_bit};
          fill_next  = fill_last ? '0 : fill_cnt + FILL_W'(1);
          match_next = '0;
        end
        VERIFY: begin
          sr_next = {sr[DATA_WIDTH-2:0], MSEQ_in_bit};
          if (!bit_match) begin
            fill_next  = '0;
            match_next = '0;
          end else if (match_last) begin
            match_next = '0;
            wpos_next  = '0;
            werr_next  = '0;
          end else begin
            match_next = match_cnt + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a received error cannot propagate.
          sr_next    = {sr[DATA_WIDTH-2:0], pred};
          bit_inc    = 1'b1;
          err_inc    = bit_err;
          pulse_next = bit_err;
          if (loss_hit) begin
            fill_next = '0;
            wpos_next = '0;
            werr_next = '0;
          end else if (win_last) begin
            wpos_next = '0;
            werr_next = '0;
          end else begin
            wpos_next = win_pos + WPOS_W'(1);
            werr_next = win_err + WERR_W'(bit_err);
          end
        end
        default: begin
          fill_next = '0;
        end
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge MSEQ_clk or posedge MSEQ_rst) begin
    if (MSEQ_rst) begin
      sr             <= '0;
      seed_q         <= '0;
      fill_cnt       <= '0;
      match_cnt      <= '0;
      win_pos        <= '0;
      win_err        <= '0;
      MSEQ_locked    <= 1'b0;
      MSEQ_err_pulse <= 1'b0;
    end else begin
      sr             <= sr_next;
      seed_q         <= MSEQ_seed;
      fill_cnt       <= fill_next;
      match_cnt      <= match_next;
      win_pos        <= wpos_next;
      win_err        <= werr_next;
      MSEQ_locked    <= (state_next == LOCKED);
      MSEQ_err_pulse <= pulse_next;
    end
  end

  mseq_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bit_cnt (
    .clk   (MSEQ_clk),
    .rst   (MSEQ_rst),
    .inc   (bit_inc),
    .clr   (MSEQ_clr_cnt),
    .count (MSEQ_bit_cnt)
  );

  mseq_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (MSEQ_clk),
    .rst   (MSEQ_rst),
    .inc   (err_inc),
    .clr   (MSEQ_clr_cnt),
    .count (MSEQ_err_cnt)
  );

endmodule
